// File: rtl/adc_src_pkg.sv
// Shared types and helpers for the ADC I/Q stream source: FSM states,
// saturating offset subtraction and the output packing order.
package adc_src_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Widest sample component the helper below supports.
  localparam int unsigned MaxW = 32;

  // Output beat is {Q, I} when set, {I, Q} otherwise.
  localparam bit PackQHigh = 1'b1;

  // a - b at MaxW+1 bits, clamped to the signed range of a w-bit value.
  // Operands must already be sign-extended to MaxW bits.
  function automatic logic signed [MaxW:0] sat_sub(input logic signed [MaxW-1:0] a,
                                                  input logic signed [MaxW-1:0] b,
                                                  input int unsigned w);
    logic signed [MaxW:0] d;
    logic signed [MaxW:0] hi;
    logic signed [MaxW:0] lo;
    d  = $signed({a[MaxW-1], a}) - $signed({b[MaxW-1], b});
    hi = ($signed({{MaxW{1'b0}}, 1'b1}) <<< (w - 1)) - $signed({{MaxW{1'b0}}, 1'b1});
    lo = ~hi;
    if (d > hi) begin
      return hi;
    end else if (d < lo) begin
      return lo;
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Accepts a push while full as long
// as a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on the pointers tells full (MSBs differ) from empty (equal).
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    rdata_o = mem_q[rptr_q[AW-1:0]];
    level_o = wptr_q - rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/adc_iq_stream_source.sv
// Captures strobed I/Q ADC samples, removes a DC offset with saturation and
// streams packed samples through a FWFT FIFO onto an AXI-Stream master.
module adc_iq_stream_source #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CW         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DW-1:0]                 adc_i,
  input  logic [DW-1:0]                 adc_q,
  input  logic                          adc_valid,
  input  logic [DW-1:0]                 offset_i,
  input  logic [DW-1:0]                 offset_q,
  input  logic                          clr_ovf,
  output logic [2*DW-1:0]               tdata_m,
  output logic                          tvalid_m,
  input  logic                          tready_m,
  output logic [CW-1:0]                 ovf_count,
  output logic                          ovf_irq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  import adc_src_pkg::*;

  localparam logic [CW-1:0] OvfMax = '1;

  state_e              state_q, state_d;
  logic                s1_valid_q;
  logic [2*DW-1:0]     s1_data_q;
  logic                s1_load;
  logic signed [MaxW:0] i_diff;
  logic signed [MaxW:0] q_diff;
  logic [DW-1:0]       i_sat;
  logic [DW-1:0]       q_sat;
  logic [2*DW-1:0]     s1_data_d;
  logic [CW-1:0]       ovf_q, ovf_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                drop;

  always_comb begin
    i_diff    = sat_sub(MaxW'($signed(adc_i)), MaxW'($signed(offset_i)), DW);
    q_diff    = sat_sub(MaxW'($signed(adc_q)), MaxW'($signed(offset_q)), DW);
    i_sat     = i_diff[DW-1:0];
    q_sat     = q_diff[DW-1:0];
    s1_data_d = PackQHigh ? {q_sat, i_sat} : {i_sat, q_sat};
  end

  always_comb begin
    state_d = state_q;
    s1_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        // Leaving RUN: the sample presented this cycle is not captured.
        if (!enable) state_d = StDrain;
        else         s1_load = adc_valid;
      end
      StDrain: begin
        if (enable)                         state_d = StRun;
        else if (fifo_empty && !s1_valid_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_load;
      if (s1_load) s1_data_q <= s1_data_d;
    end
  end

  // A full FIFO still takes the stage-1 sample when the head leaves this cycle.
  always_comb begin
    tvalid_m = !fifo_empty;
    pop      = tvalid_m && tready_m;
    push     = s1_valid_q && (!fifo_full || pop);
    drop     = s1_valid_q && !push;
  end

  sync_fifo_fwft #(
    .Width (2 * DW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (s1_data_q),
    .pop_i   (pop),
    .rdata_o (tdata_m),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Clear and a coincident drop leave the count at one so the drop is kept.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = CW'(drop);
    end else if (drop && (ovf_q != OvfMax)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    ovf_count = ovf_q;
    ovf_irq   = drop;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_adc_iq_stream_source.sv
// Randomized bench for adc_iq_stream_source: a cycle-level reference model
// fills a scoreboard queue, a monitor checks every output handshake against it.
module tb_adc_iq_stream_source;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] adc_i, adc_q, offset_i, offset_q;
  logic        adc_valid;
  logic        clr_ovf;
  logic        tready_m;

  logic [31:0] tdata_m;
  logic        tvalid_m;
  logic [15:0] ovf_count;
  logic        ovf_irq;
  logic [4:0]  fifo_level;
  logic        busy;

  logic [31:0] tdata_s;
  logic        tvalid_s;
  logic [3:0]  ovf_count_s;
  logic        ovf_irq_s;
  logic [4:0]  fifo_level_s;
  logic        busy_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_iq_stream_source u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .adc_i      (adc_i),
    .adc_q      (adc_q),
    .adc_valid  (adc_valid),
    .offset_i   (offset_i),
    .offset_q   (offset_q),
    .clr_ovf    (clr_ovf),
    .tdata_m    (tdata_m),
    .tvalid_m   (tvalid_m),
    .tready_m   (tready_m),
    .ovf_count  (ovf_count),
    .ovf_irq    (ovf_irq),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  // Narrow-counter instance, used only to check counter saturation.
  adc_iq_stream_source #(.CW(4)) u_dut_sat (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .adc_i      (adc_i),
    .adc_q      (adc_q),
    .adc_valid  (adc_valid),
    .offset_i   (offset_i),
    .offset_q   (offset_q),
    .clr_ovf    (clr_ovf),
    .tdata_m    (tdata_s),
    .tvalid_m   (tvalid_s),
    .tready_m   (tready_m),
    .ovf_count  (ovf_count_s),
    .ovf_irq    (ovf_irq_s),
    .fifo_level (fifo_level_s),
    .busy       (busy_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  // Reference model state: 0 idle, 1 run, 2 drain.
  int          mstate = 0;
  bit          ms1_v  = 1'b0;
  logic [31:0] ms1_data;
  logic [31:0] mfifo[$];
  logic [31:0] exp_q[$];
  int          mcnt   = 0;
  int          mcnt4  = 0;
  bit          primed = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mstate = 0;
      ms1_v  = 1'b0;
      mfifo.delete();
      exp_q.delete();
      mcnt   = 0;
      mcnt4  = 0;
      primed = 1'b1;
    end else if (primed) begin
      int sz;
      bit s1v_old, pop, acc, drop;
      int di, dq;
      sz      = mfifo.size();
      s1v_old = ms1_v;
      pop     = (sz > 0) && tready_m;
      acc     = ms1_v && ((sz < Depth) || pop);
      drop    = ms1_v && !acc;
      check("tvalid", 64'(tvalid_m), 64'(sz > 0));
      check("fifo_level", 64'(fifo_level), 64'(sz));
      check("busy", 64'(busy), 64'(mstate != 0));
      check("ovf_irq", 64'(ovf_irq), 64'(drop));
      check("ovf_count", 64'(ovf_count), 64'(mcnt));
      check("ovf_count_cw4", 64'(ovf_count_s), 64'(mcnt4));
      if (pop) void'(mfifo.pop_front());
      if (acc) begin
        mfifo.push_back(ms1_data);
        exp_q.push_back(ms1_data);
      end
      if (clr_ovf) begin
        mcnt  = drop ? 1 : 0;
        mcnt4 = drop ? 1 : 0;
      end else if (drop) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15)   mcnt4++;
      end
      ms1_v = (mstate == 1) && enable && adc_valid;
      if (ms1_v) begin
        di = int'($signed(adc_i)) - int'($signed(offset_i));
        dq = int'($signed(adc_q)) - int'($signed(offset_q));
        ms1_data = {sat16(dq), sat16(di)};
      end
      case (mstate)
        0: if (enable) mstate = 1;
        1: if (!enable) mstate = 2;
        default: begin
          if (enable) mstate = 1;
          else if ((sz == 0) && !s1v_old) mstate = 0;
        end
      endcase
    end
  end

  // Monitor: every accepted beat must be the oldest expected sample.
  always @(negedge clk) begin
    if (primed && !reset && (tvalid_m === 1'b1) && (tready_m === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_unexpected @%0t: got %0h expected none", $time, tdata_m);
      end else begin
        check("tdata", 64'(tdata_m), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_sample();
    adc_i = 16'($urandom);
    adc_q = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; adc_valid = 1'b0; clr_ovf = 1'b0; tready_m = 1'b1;
    adc_i = '0; adc_q = '0; offset_i = '0; offset_q = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Offset saturation on both components.
    enable = 1'b1;
    step();
    adc_i = 16'h7FF0; offset_i = 16'hFFE0; adc_q = 16'h8005; offset_q = 16'h0010;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    repeat (4) step();
    offset_i = 16'($urandom_range(0, 255)); offset_q = 16'($urandom_range(0, 255));

    // Back-pressure overflow: 20 samples into 16 entries.
    tready_m = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    repeat (3) step();
    tready_m = 1'b1;
    repeat (20) step();

    // Full FIFO with a pop every cycle keeps accepting.
    tready_m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    repeat (2) step();
    tready_m = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    repeat (20) step();

    // Drain with samples held back, inputs ignored meanwhile.
    tready_m = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    repeat (2) step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rand_sample(); adc_valid = 1'($urandom); step();
    end
    adc_valid = 1'b0;
    tready_m = 1'b1;
    repeat (10) step();

    // Clear coinciding with the eighth drop, then saturate the narrow counter.
    enable = 1'b1;
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    tready_m = 1'b0;
    for (int k = 0; k < 24; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0; clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    repeat (2) step();
    tready_m = 1'b1;
    repeat (20) step();

    // Random traffic with enable toggling and occasional clears.
    for (int k = 0; k < 2000; k++) begin
      rand_sample();
      if ($urandom_range(0, 31) == 0) begin
        offset_i = 16'($urandom); offset_q = 16'($urandom);
      end
      enable    = ($urandom_range(0, 15) != 0);
      adc_valid = ($urandom_range(0, 3) != 0);
      tready_m  = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 63) == 0);
      step();
    end
    clr_ovf = 1'b0;

    // Reset mid-stream with nine entries queued.
    enable = 1'b1; adc_valid = 1'b0; tready_m = 1'b1;
    repeat (25) step();
    tready_m = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rand_sample(); adc_valid = 1'b1; step();
    end
    adc_valid = 1'b0;
    step();
    tready_m = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 200; k++) begin
      rand_sample();
      enable = 1'b1; adc_valid = 1'($urandom); tready_m = 1'($urandom);
      step();
    end

    // Final drain: everything predicted must have been delivered.
    enable = 1'b0; adc_valid = 1'b0; tready_m = 1'b1;
    repeat (40) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
